// File: rtl/datapath_issue.sv
// Issue controller for the 16x32 register-file/ALU datapath.
// Decoded instructions are accepted through a valid/ready handshake. They then flow
// through a fixed LAT-stage pipeline whose first stage drives the execute controls
// and whose last stage drives the register-file write controls. A 16-bit scoreboard
// holds back any instruction that touches a register whose write is still pending.
module datapath_issue #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic        in_form,
    input  logic [1:0]  in_vec,
    input  logic [3:0]  in_A,
    input  logic [3:0]  in_B,
    input  logic [3:0]  in_C,
    input  logic [3:0]  in_D,
    input  logic [3:0]  in_Y1,
    input  logic [3:0]  in_Y2,
    input  logic [1:0]  in_write,
    input  logic [3:0]  zero_reg,
    output logic [2:0]  dp_op,
    output logic        dp_form,
    output logic [1:0]  dp_vec,
    output logic [3:0]  dp_A,
    output logic [3:0]  dp_B,
    output logic [3:0]  dp_C,
    output logic [3:0]  dp_D,
    output logic [3:0]  dp_Y1,
    output logic [3:0]  dp_Y2,
    output logic [1:0]  dp_write,
    output logic [15:0] busy,
    output logic        idle,
    output logic [15:0] stall_cnt
);

    // One in-flight instruction. The write field holds the sanitised enables.
    typedef struct packed {
        logic [2:0] op;
        logic       form;
        logic [1:0] vec;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] y1;
        logic [3:0] y2;
        logic [1:0] wr;
    } instr_t;

    logic [LAT-1:0] r_valid;
    instr_t         r_stage [LAT];
    logic [15:0]    r_busy;
    logic [15:0]    r_stallCnt;

    logic           w_wr0;
    logic           w_wr1;
    instr_t         w_in;
    logic [15:0]    w_srcMask;
    logic [15:0]    w_dstMask;
    logic [15:0]    w_retiring;
    logic           w_ready;
    logic           w_accept;
    instr_t         w_exec;
    instr_t         w_wb;

    function automatic logic [15:0] regBit(input logic [3:0] r);
        return 16'h0001 << r;
    endfunction

    // Sanitise the incoming write enables: writes to the hard-zero register are
    // dropped, and when both ports target the same register only Y1 is kept.
    always_comb begin
        w_wr0 = in_write[0] && (in_Y1 != zero_reg);
        w_wr1 = in_write[1] && (in_Y2 != zero_reg)
                && !(in_write[0] && (in_Y1 == in_Y2));
        w_in.op   = in_op;
        w_in.form = in_form;
        w_in.vec  = in_vec;
        w_in.a    = in_A;
        w_in.b    = in_B;
        w_in.c    = in_C;
        w_in.d    = in_D;
        w_in.y1   = in_Y1;
        w_in.y2   = in_Y2;
        w_in.wr   = {w_wr1, w_wr0};
    end

    // Hazard check. The register retiring this cycle is treated as free, so a
    // dependent instruction can issue in the same cycle its producer writes.
    // Readiness depends only on state and the offered fields, never on in_valid.
    always_comb begin
        w_srcMask = 16'h0000;
        if (in_A != zero_reg) w_srcMask = w_srcMask | regBit(in_A);
        if (in_B != zero_reg) w_srcMask = w_srcMask | regBit(in_B);
        if (in_C != zero_reg) w_srcMask = w_srcMask | regBit(in_C);
        if (in_D != zero_reg) w_srcMask = w_srcMask | regBit(in_D);
        w_dstMask = 16'h0000;
        if (w_wr0) w_dstMask = w_dstMask | regBit(in_Y1);
        if (w_wr1) w_dstMask = w_dstMask | regBit(in_Y2);
        w_retiring = 16'h0000;
        if (r_valid[LAT-1] && r_stage[LAT-1].wr[0]) w_retiring = w_retiring | regBit(r_stage[LAT-1].y1);
        if (r_valid[LAT-1] && r_stage[LAT-1].wr[1]) w_retiring = w_retiring | regBit(r_stage[LAT-1].y2);
        w_ready  = (((w_srcMask | w_dstMask) & r_busy & ~w_retiring) == 16'h0000);
        w_accept = in_valid && w_ready;
    end

    // Instruction pipeline: a new entry (or a bubble) enters every cycle and
    // everything moves one stage per cycle; reset discards all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= w_accept;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Instruction fields travel alongside the valid bits; outputs are masked by
    // valid, so the field registers need no reset.
    always_ff @(posedge clk) begin
        r_stage[0] <= w_in;
        for (int i = 1; i < LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
        end
    end

    // Scoreboard: retire the write-stage destinations, then mark the new ones.
    // Setting after clearing lets a LAT=1 producer/consumer pair share a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 16'h0000;
        end else begin
            r_busy <= (r_busy & ~w_retiring) | (w_accept ? w_dstMask : 16'h0000);
        end
    end

    // Saturating count of cycles where the decoder offered but was held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= 16'h0000;
        end else if (in_valid && !w_ready && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'h0001;
        end
    end

    // Drive the datapath from the execute and write stages, zero when empty.
    always_comb begin
        w_exec   = r_valid[0] ? r_stage[0] : '0;
        w_wb     = r_valid[LAT-1] ? r_stage[LAT-1] : '0;
        dp_op    = w_exec.op;
        dp_form  = w_exec.form;
        dp_vec   = w_exec.vec;
        dp_A     = w_exec.a;
        dp_B     = w_exec.b;
        dp_C     = w_exec.c;
        dp_D     = w_exec.d;
        dp_Y1    = w_wb.y1;
        dp_Y2    = w_wb.y2;
        dp_write = w_wb.wr;
    end

    assign in_ready  = w_ready;
    assign busy      = r_busy;
    assign stall_cnt = r_stallCnt;
    assign idle      = (r_valid == '0) && (r_busy == 16'h0000);

endmodule

// File: tb/tb_datapath_issue.sv
// Testbench for datapath_issue: three instances (LAT = 1, 2, 3) share one stimulus
// stream and are each checked every cycle against a history-window model, with
// directed scenarios pinning concrete values.
module tb_datapath_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_op;
    logic        in_form;
    logic [1:0]  in_vec;
    logic [3:0]  in_A, in_B, in_C, in_D, in_Y1, in_Y2, zero_reg;
    logic [1:0]  in_write;

    logic        inReady [3];
    logic [2:0]  dpOp    [3];
    logic        dpForm  [3];
    logic [1:0]  dpVec   [3];
    logic [3:0]  dpA     [3];
    logic [3:0]  dpB     [3];
    logic [3:0]  dpC     [3];
    logic [3:0]  dpD     [3];
    logic [3:0]  dpY1    [3];
    logic [3:0]  dpY2    [3];
    logic [1:0]  dpWrite [3];
    logic [15:0] busy    [3];
    logic        idle    [3];
    logic [15:0] stallCnt[3];

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;
    int cyc        = 16;

    // Free-running clock.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        datapath_issue #(.LAT(g + 1)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (inReady[g]),
            .in_op    (in_op),
            .in_form  (in_form),
            .in_vec   (in_vec),
            .in_A     (in_A),
            .in_B     (in_B),
            .in_C     (in_C),
            .in_D     (in_D),
            .in_Y1    (in_Y1),
            .in_Y2    (in_Y2),
            .in_write (in_write),
            .zero_reg (zero_reg),
            .dp_op    (dpOp[g]),
            .dp_form  (dpForm[g]),
            .dp_vec   (dpVec[g]),
            .dp_A     (dpA[g]),
            .dp_B     (dpB[g]),
            .dp_C     (dpC[g]),
            .dp_D     (dpD[g]),
            .dp_Y1    (dpY1[g]),
            .dp_Y2    (dpY2[g]),
            .dp_write (dpWrite[g]),
            .busy     (busy[g]),
            .idle     (idle[g]),
            .stall_cnt(stallCnt[g])
        );
    end

    // Model record of what was accepted in a given cycle (v=0: nothing accepted).
    typedef struct {
        bit       v;
        bit [2:0] op;
        bit       form;
        bit [1:0] vec;
        bit [3:0] a, b, c, d, y1, y2;
        bit [1:0] wr;
    } rec_t;

    rec_t        hist [3][8];
    logic [15:0] expStall [3];

    task automatic checkOutput(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s lat=%0d t=%0t: got %0h expected %0h", name, lat, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] bitOf(input logic [3:0] r);
        return 16'h0001 << r;
    endfunction

    function automatic logic [15:0] destsOf(input rec_t r);
        logic [15:0] m;
        m = 16'h0000;
        if (r.v && r.wr[0]) m = m | bitOf(r.y1);
        if (r.v && r.wr[1]) m = m | bitOf(r.y2);
        return m;
    endfunction

    // Compare process: each cycle the model derives the expected outputs of every
    // instance from the accept history of the last LAT cycles, checks them, and
    // then records what this cycle accepts.
    always @(negedge clk) begin
        rec_t        ex, wb, nr;
        logic [15:0] bz, ret, haz;
        logic [1:0]  wr;
        bit          anyV, rdy;
        int          lat;
        for (int k = 0; k < 3; k++) begin
            lat = k + 1;
            ex  = hist[k][(cyc - 1) & 7];
            wb  = hist[k][(cyc - lat) & 7];
            bz   = 16'h0000;
            anyV = 1'b0;
            for (int j = 1; j <= lat; j++) begin
                bz   = bz | destsOf(hist[k][(cyc - j) & 7]);
                anyV = anyV | hist[k][(cyc - j) & 7].v;
            end
            ret = destsOf(wb);
            wr = in_write;
            if (in_Y1 == zero_reg) wr[0] = 1'b0;
            if (in_Y2 == zero_reg) wr[1] = 1'b0;
            if (in_Y1 == in_Y2 && wr == 2'b11) wr[1] = 1'b0;
            haz = 16'h0000;
            if (in_A != zero_reg) haz = haz | bitOf(in_A);
            if (in_B != zero_reg) haz = haz | bitOf(in_B);
            if (in_C != zero_reg) haz = haz | bitOf(in_C);
            if (in_D != zero_reg) haz = haz | bitOf(in_D);
            if (wr[0]) haz = haz | bitOf(in_Y1);
            if (wr[1]) haz = haz | bitOf(in_Y2);
            rdy = ((haz & bz & ~ret) == 16'h0000);
            if (checkEn) begin
                checkOutput("in_ready", lat, 32'(inReady[k]), 32'(rdy));
                checkOutput("busy", lat, 32'(busy[k]), 32'(bz));
                checkOutput("idle", lat, 32'(idle[k]), 32'(!anyV && bz == 16'h0000));
                checkOutput("stall_cnt", lat, 32'(stallCnt[k]), 32'(expStall[k]));
                checkOutput("exec_ctl", lat,
                    32'({dpOp[k], dpForm[k], dpVec[k], dpA[k], dpB[k], dpC[k], dpD[k]}),
                    ex.v ? 32'({ex.op, ex.form, ex.vec, ex.a, ex.b, ex.c, ex.d}) : 32'h0);
                checkOutput("write_ctl", lat,
                    32'({dpY1[k], dpY2[k], dpWrite[k]}),
                    wb.v ? 32'({wb.y1, wb.y2, wb.wr}) : 32'h0);
            end
            nr.v    = in_valid && rdy && !rst;
            nr.op   = in_op;
            nr.form = in_form;
            nr.vec  = in_vec;
            nr.a    = in_A;
            nr.b    = in_B;
            nr.c    = in_C;
            nr.d    = in_D;
            nr.y1   = in_Y1;
            nr.y2   = in_Y2;
            nr.wr   = wr;
            hist[k][cyc & 7] = nr;
            if (rst) begin
                for (int j = 0; j < 8; j++) hist[k][j].v = 1'b0;
                expStall[k] = 16'h0000;
            end else if (in_valid && !rdy && expStall[k] != 16'hFFFF) begin
                expStall[k] = expStall[k] + 16'h0001;
            end
        end
        cyc++;
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input bit v, input bit [3:0] a, input bit [3:0] b, input bit [3:0] c,
                                 input bit [3:0] d, input bit [3:0] y1, input bit [3:0] y2,
                                 input bit [1:0] wr, input bit r);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        in_op    = 3'($urandom);
        in_form  = 1'($urandom);
        in_vec   = 2'($urandom);
        in_A     = a;
        in_B     = b;
        in_C     = c;
        in_D     = d;
        in_Y1    = y1;
        in_Y2    = y2;
        in_write = wr;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
    endtask

    // Directed scenarios first, then a long randomized run.
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_form = 1'b0; in_vec = '0;
        in_A = '0; in_B = '0; in_C = '0; in_D = '0; in_Y1 = '0; in_Y2 = '0;
        in_write = '0; zero_reg = 4'd0;
        @(posedge clk);
        #1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_idle", 2, 32'(idle[1]), 32'd1);
        checkOutput("reset_ready", 2, 32'(inReady[1]), 32'd1);
        checkOutput("reset_dp_write", 2, 32'(dpWrite[1]), 32'd0);
        bubbles(2);

        // Independent back-to-back issue, LAT=2.
        applyStimulus(1'b1, 1, 2, 0, 0, 3, 0, 2'b01, 1'b0);
        @(negedge clk);
        checkOutput("ind_ready0", 2, 32'(inReady[1]), 32'd1);
        applyStimulus(1'b1, 4, 0, 0, 0, 5, 0, 2'b01, 1'b0);
        @(negedge clk);
        checkOutput("ind_ready1", 2, 32'(inReady[1]), 32'd1);
        checkOutput("ind_dpA1", 2, 32'(dpA[1]), 32'd1);
        bubbles(1);
        @(negedge clk);
        checkOutput("ind_dpA2", 2, 32'(dpA[1]), 32'd4);
        checkOutput("ind_wr2", 2, 32'({dpWrite[1], dpY1[1]}), 32'h13);
        bubbles(1);
        @(negedge clk);
        checkOutput("ind_wr3", 2, 32'({dpWrite[1], dpY1[1]}), 32'h15);
        bubbles(4);

        // RAW stall, LAT=2.
        applyStimulus(1'b1, 0, 0, 0, 0, 7, 0, 2'b01, 1'b0);
        applyStimulus(1'b1, 7, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("raw_ready1", 2, 32'(inReady[1]), 32'd0);
        checkOutput("raw_busy1", 2, 32'(busy[1]), 32'h0080);
        applyStimulus(1'b1, 7, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("raw_ready2", 2, 32'(inReady[1]), 32'd1);
        checkOutput("raw_busy2", 2, 32'(busy[1]), 32'h0080);
        bubbles(1);
        @(negedge clk);
        checkOutput("raw_stall", 2, 32'(stallCnt[1]), 32'd1);
        bubbles(4);

        // Back-to-back RAW, LAT=1.
        applyStimulus(1'b1, 0, 0, 0, 0, 3, 0, 2'b01, 1'b0);
        applyStimulus(1'b1, 3, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("lat1_ready", 1, 32'(inReady[0]), 32'd1);
        checkOutput("lat1_busy1", 1, 32'(busy[0]), 32'h0008);
        bubbles(1);
        @(negedge clk);
        checkOutput("lat1_busy2", 1, 32'(busy[0]), 32'h0000);
        checkOutput("lat1_stall", 1, 32'(stallCnt[0]), 32'd0);
        bubbles(4);

        // Hard-zero register sanitisation.
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 6, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("zero_ready0", 2, 32'(inReady[1]), 32'd1);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("zero_busy", 2, 32'(busy[1]), 32'h0040);
        checkOutput("zero_ready1", 2, 32'(inReady[1]), 32'd1);
        bubbles(1);
        @(negedge clk);
        checkOutput("zero_wr", 2, 32'({dpWrite[1], dpY2[1]}), 32'h26);
        bubbles(4);

        // Y1 wins over Y2 on the same register.
        applyStimulus(1'b1, 0, 0, 0, 0, 9, 9, 2'b11, 1'b0);
        bubbles(1);
        @(negedge clk);
        checkOutput("same_busy", 2, 32'(busy[1]), 32'h0200);
        bubbles(1);
        @(negedge clk);
        checkOutput("same_wr", 2, 32'({dpWrite[1], dpY1[1]}), 32'h19);
        bubbles(4);

        // Reset drops an in-flight write, LAT=3.
        applyStimulus(1'b1, 0, 0, 0, 0, 2, 0, 2'b01, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("rst_busy_pre", 3, 32'(busy[2]), 32'h0004);
        bubbles(1);
        @(negedge clk);
        checkOutput("rst_wr2", 3, 32'(dpWrite[2]), 32'd0);
        checkOutput("rst_busy", 3, 32'(busy[2]), 32'h0000);
        checkOutput("rst_idle", 3, 32'(idle[2]), 32'd1);
        checkOutput("rst_stall", 2, 32'(stallCnt[1]), 32'd0);
        bubbles(1);
        @(negedge clk);
        checkOutput("rst_wr3", 3, 32'(dpWrite[2]), 32'd0);
        bubbles(2);

        // Randomized run; zero_reg changes only after the pipelines drain.
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 299) begin
                bubbles(6);
                zero_reg = 4'($urandom_range(0, 7));
            end
            applyStimulus($urandom_range(0, 9) < 7,
                          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
        end
        bubbles(4);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
